// File: rtl/sram_ctrl.sv
// sram_ctrl: runs read/write cycles on an external asynchronous 16-bit SRAM,
// one request at a time, with registered strobes and programmable wait states.
module sram_ctrl #(
    parameter int AW      = 20,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2,
    parameter int TURN    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [21:0]   addr,
    input  logic [15:0]   d_in,
    output logic [15:0]   d_out,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] sram_a,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_lb_n,
    output logic          sram_ub_n
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_TURN} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    state_t     w_done_state;
    logic       w_done_busy;
    logic [3:0] w_turn_cnt;

    // With no turnaround the access finishes straight into IDLE.
    assign w_done_state = (TURN == 0) ? S_IDLE : S_TURN;
    assign w_done_busy  = (TURN != 0);
    assign w_turn_cnt   = 4'(TURN - 1);

    generate
        if (AW < 22) begin : g_unused
            logic w_unused;
            assign w_unused = ^addr[21:AW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            d_out      <= 16'd0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            sram_a     <= '0;
            sram_dq_o  <= 16'd0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            ack <= 1'b0;
            case (r_state)
                S_IDLE: if (req) begin
                    sram_a    <= addr[AW-1:0];
                    sram_dq_o <= d_in;
                    busy      <= 1'b1;
                    sram_ce_n <= 1'b0;
                    if (we) begin
                        r_state    <= S_WSETUP;
                        sram_lb_n  <= ~be[0];
                        sram_ub_n  <= ~be[1];
                        sram_dq_oe <= 1'b1;
                    end else begin
                        r_state   <= S_RD;
                        r_cnt     <= 4'(WAIT_RD);
                        sram_oe_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                        sram_ub_n <= 1'b0;
                    end
                end
                S_RD: if (r_cnt == 4'd0) begin
                    d_out     <= sram_dq_i;
                    ack       <= 1'b1;
                    busy      <= w_done_busy;
                    r_state   <= w_done_state;
                    r_cnt     <= w_turn_cnt;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_WSETUP: begin
                    r_state   <= S_WPULSE;
                    r_cnt     <= 4'(WAIT_WR);
                    sram_we_n <= 1'b0;
                end
                S_WPULSE: if (r_cnt == 4'd0) begin
                    r_state   <= S_WHOLD;
                    sram_we_n <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_WHOLD: begin
                    ack        <= 1'b1;
                    busy       <= w_done_busy;
                    r_state    <= w_done_state;
                    r_cnt      <= w_turn_cnt;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                end
                S_TURN: if (r_cnt == 4'd0) begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized checks of sram_ctrl against a word-level memory model;
// a second instance with TURN = 0 covers back-to-back accesses.
module tb_sram_ctrl;
    localparam int RDW = 2;
    localparam int WRW = 2;
    localparam int TRN = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b1, we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [21:0] addr = 22'd0;
    logic [15:0] d_in = 16'd0;
    logic [15:0] d_out, sram_dq_o, sram_dq_i;
    logic        ack, busy, sram_dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;
    logic [19:0] sram_a;

    logic        req_b = 1'b1, we_b = 1'b0;
    logic [1:0]  be_b = 2'b00;
    logic [21:0] addr_b = 22'd0;
    logic [15:0] d_in_b = 16'd0;
    logic [15:0] d_out_b, sram_dq_o_b, sram_dq_i_b;
    logic        ack_b, busy_b, sram_dq_oe_b, ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b;
    logic [19:0] sram_a_b;

    sram_ctrl #(.AW(20), .WAIT_RD(RDW), .WAIT_WR(WRW), .TURN(TRN)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .d_in(d_in),
        .d_out(d_out), .ack(ack), .busy(busy), .sram_a(sram_a), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
        .sram_we_n(we_n), .sram_lb_n(lb_n), .sram_ub_n(ub_n)
    );

    sram_ctrl #(.AW(20), .WAIT_RD(RDW), .WAIT_WR(WRW), .TURN(0)) u_b2b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .be(be_b), .addr(addr_b), .d_in(d_in_b),
        .d_out(d_out_b), .ack(ack_b), .busy(busy_b), .sram_a(sram_a_b), .sram_dq_o(sram_dq_o_b),
        .sram_dq_oe(sram_dq_oe_b), .sram_dq_i(sram_dq_i_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
        .sram_we_n(we_n_b), .sram_lb_n(lb_n_b), .sram_ub_n(ub_n_b)
    );

    // Asynchronous SRAM devices: combinational read, byte writes while ce and we are low.
    logic [15:0] mem_a [0:1048575];
    logic [15:0] mem_b [0:1048575];
    assign sram_dq_i   = mem_a[sram_a];
    assign sram_dq_i_b = mem_b[sram_a_b];
    always @(posedge clk) begin
        if (!ce_n && !we_n && sram_dq_oe) begin
            if (!lb_n) mem_a[sram_a][7:0] <= sram_dq_o[7:0];
            if (!ub_n) mem_a[sram_a][15:8] <= sram_dq_o[15:8];
        end
        if (!ce_n_b && !we_n_b && sram_dq_oe_b) begin
            if (!lb_n_b) mem_b[sram_a_b][7:0] <= sram_dq_o_b[7:0];
            if (!ub_n_b) mem_b[sram_a_b][15:8] <= sram_dq_o_b[15:8];
        end
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem [logic [19:0]];
    logic [19:0] pool [8];

    task automatic do_access(input logic w, input logic [1:0] b, input logic [19:0] a,
                             input logic [15:0] d, input int gk);
        int k, ack_k, oe_c, we_c, bus_c, ce_c, bad, tk, exp_ack;
        logic [15:0] old_q, old_m, exp_m;
        old_q = d_out;
        ack_k = -1; k = 0; oe_c = 0; we_c = 0; bus_c = 0; ce_c = 0; bad = 0;
        exp_ack = w ? WRW + 3 : RDW + 1;
        req = 1'b1; we = w; be = b; addr = {2'b10, a}; d_in = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); be = 2'($urandom); addr = 22'($urandom); d_in = 16'($urandom);
        while (ack_k < 0 && k < 64) begin
            if (k == gk) begin req = 1'b1; we = 1'b1; addr = {2'b10, ~a}; end
            if (k == gk + 1) req = 1'b0;
            if (ack) begin
                ack_k = k;
                if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'h1f || sram_dq_oe !== 1'b0) bad++;
            end else begin
                if (!oe_n) oe_c++;
                if (!we_n) we_c++;
                if (sram_dq_oe) bus_c++;
                if (!ce_n) ce_c++;
                if (sram_a !== a || busy !== 1'b1) bad++;
                if ({ub_n, lb_n} !== (w ? ~b : 2'b00)) bad++;
                if (w && (sram_dq_o !== d || oe_n !== 1'b1)) bad++;
                if (!w && (we_n !== 1'b1 || sram_dq_oe !== 1'b0)) bad++;
                @(posedge clk); #1;
                k++;
            end
        end
        tk = 0;
        while (busy && tk < 16) begin
            @(posedge clk); #1;
            tk++;
            if (ack) bad++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ack || busy || sram_a !== a || ce_n !== 1'b1) bad++;
        end
        checks++; if (ack_k !== exp_ack) begin errors++; $display("FAIL ack_latency a=%h got %0d exp %0d", a, ack_k, exp_ack); end
        checks++; if (ce_c !== exp_ack) begin errors++; $display("FAIL ce_window a=%h got %0d exp %0d", a, ce_c, exp_ack); end
        checks++; if (oe_c !== (w ? 0 : RDW + 1)) begin errors++; $display("FAIL oe_window a=%h got %0d exp %0d", a, oe_c, w ? 0 : RDW + 1); end
        checks++; if (we_c !== (w ? WRW + 1 : 0)) begin errors++; $display("FAIL we_window a=%h got %0d exp %0d", a, we_c, w ? WRW + 1 : 0); end
        checks++; if (bus_c !== (w ? WRW + 3 : 0)) begin errors++; $display("FAIL dq_oe_window a=%h got %0d exp %0d", a, bus_c, w ? WRW + 3 : 0); end
        checks++; if (tk !== TRN) begin errors++; $display("FAIL turnaround a=%h got %0d exp %0d", a, tk, TRN); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL strobe_rules a=%h got %0d violations exp 0", a, bad); end
        if (w) begin
            old_m = 16'h0000;
            if (ref_mem.exists(a)) old_m = ref_mem[a];
            exp_m = {b[1] ? d[15:8] : old_m[15:8], b[0] ? d[7:0] : old_m[7:0]};
            ref_mem[a] = exp_m;
            checks++; if (mem_a[a] !== exp_m) begin errors++; $display("FAIL write_mem a=%h got %h exp %h", a, mem_a[a], exp_m); end
            checks++; if (d_out !== old_q) begin errors++; $display("FAIL dout_hold a=%h got %h exp %h", a, d_out, old_q); end
        end else begin
            checks++; if (d_out !== ref_mem[a]) begin errors++; $display("FAIL read_data a=%h got %h exp %h", a, d_out, ref_mem[a]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; we = 1'b0; req_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n, sram_dq_oe, ack, busy} !== 8'b11111000) begin
            errors++; $display("FAIL reset_strobes got %b exp 11111000", {ce_n, oe_n, we_n, lb_n, ub_n, sram_dq_oe, ack, busy}); end
        checks++; if ({d_out, sram_dq_o, sram_a} !== 52'd0) begin
            errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", d_out, sram_dq_o, sram_a); end
        checks++; if ({ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b, sram_dq_oe_b, ack_b, busy_b} !== 8'b11111000) begin
            errors++; $display("FAIL reset_strobes_b got %b exp 11111000", {ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b, sram_dq_oe_b, ack_b, busy_b}); end
        checks++; if (d_out_b !== 16'd0) begin errors++; $display("FAIL reset_dout_b got %h exp 0000", d_out_b); end
        rst = 1'b0; req = 1'b0; req_b = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || ce_n !== 1'b1 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_no_start got busy=%b ce_n=%b exp 0/1", busy, ce_n); end
    endtask

    task automatic test_read();
        do_access(1'b1, 2'b11, 20'h12345, 16'hA5C3, -1);
        do_access(1'b0, 2'b00, 20'h12345, 16'h0000, -1);
        checks++; if (d_out !== 16'hA5C3) begin errors++; $display("FAIL read_fixed got %h exp a5c3", d_out); end
    endtask

    task automatic test_write();
        do_access(1'b1, 2'b11, 20'h00010, 16'h1234, -1);
        do_access(1'b1, 2'b10, 20'h00010, 16'hBEEF, -1);
        checks++; if (mem_a[20'h00010] !== 16'hBE34) begin errors++; $display("FAIL write_high_byte got %h exp be34", mem_a[20'h00010]); end
    endtask

    task automatic test_be_zero();
        do_access(1'b1, 2'b00, 20'h00010, 16'h5555, -1);
        checks++; if (mem_a[20'h00010] !== 16'hBE34) begin errors++; $display("FAIL be_zero_mem got %h exp be34", mem_a[20'h00010]); end
    endtask

    task automatic test_busy_guard();
        do_access(1'b0, 2'b00, 20'h00010, 16'h0000, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            pool[i] = 20'($urandom);
            do_access(1'b1, 2'b11, pool[i], 16'($urandom), -1);
        end
        for (int i = 0; i < 24; i++)
            do_access(1'($urandom_range(1)), 2'($urandom_range(3)), pool[$urandom_range(7)], 16'($urandom), -1);
    endtask

    task automatic test_back_to_back();
        int k;
        logic [19:0] a1;
        logic [15:0] d1;
        a1 = 20'($urandom); d1 = 16'($urandom);
        req_b = 1'b1; we_b = 1'b1; be_b = 2'b11; addr_b = {2'b10, a1}; d_in_b = d1;
        @(posedge clk); #1;
        we_b = 1'b0; d_in_b = ~d1;
        k = 0;
        while (!ack_b && k < 32) begin @(posedge clk); #1; k++; end
        checks++; if (k !== WRW + 3) begin errors++; $display("FAIL b2b_wr_latency got %0d exp %0d", k, WRW + 3); end
        @(posedge clk); #1;
        req_b = 1'b0;
        checks++; if (busy_b !== 1'b1 || ce_n_b !== 1'b0 || oe_n_b !== 1'b0 || sram_a_b !== a1) begin
            errors++; $display("FAIL b2b_accept got busy=%b ce_n=%b oe_n=%b a=%h exp 1/0/0/%h", busy_b, ce_n_b, oe_n_b, sram_a_b, a1); end
        k = 0;
        while (!ack_b && k < 32) begin @(posedge clk); #1; k++; end
        checks++; if (k !== RDW + 1) begin errors++; $display("FAIL b2b_rd_latency got %0d exp %0d", k, RDW + 1); end
        checks++; if (d_out_b !== d1) begin errors++; $display("FAIL b2b_data got %h exp %h", d_out_b, d1); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int k;
        req = 1'b1; we = 1'b1; be = 2'b11; addr = {2'b10, 20'hFFFFF}; d_in = 16'h0F0F;
        @(posedge clk); #1;
        req = 1'b0;
        k = 0;
        while (we_n && k < 16) begin @(posedge clk); #1; k++; end
        checks++; if (we_n !== 1'b0) begin errors++; $display("FAIL mid_reach_wpulse got we_n=%b exp 0", we_n); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ce_n, we_n, oe_n, lb_n, ub_n, sram_dq_oe, ack, busy} !== 8'b11111000) begin
            errors++; $display("FAIL mid_reset_strobes got %b exp 11111000", {ce_n, we_n, oe_n, lb_n, ub_n, sram_dq_oe, ack, busy}); end
        rst = 1'b0;
        k = 0;
        repeat (8) begin @(posedge clk); #1; if (ack || busy) k++; end
        checks++; if (k !== 0) begin errors++; $display("FAIL mid_no_ack got %0d active cycles exp 0", k); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_be_zero();
        test_busy_guard();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Downstream stage of the memory address decoder: services every bus access whose address decodes to the SRAM window (addr[23:22] == 2'b10) and runs the cycle on the external asynchronous 16-bit SRAM. It accepts one request at a time via a req/ack handshake. It generates registered, glitch-free chip, output and write strobes with programmable wait states, and returns read data in a holding register.

## Interface
Parameters:
- AW, 20, external SRAM word-address width; only addr[AW-1:0] is used.
- WAIT_RD, 2, extra read wait states (0..15).
- WAIT_WR, 2, extra write-pulse wait states (0..15).
- TURN, 1, idle turnaround cycles after each access (0..3).

Ports (clock and reset first):
- clk  in  1  system clock; one clock domain; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  access request, level; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- be  in  2  byte enables for writes: be[0] = low byte, be[1] = high byte.
- addr  in  22  word address within the SRAM window.
- d_in  in  16  write data; sampled with req.
- d_out  out  16  read data register; updated only on read completion.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- sram_a  out  AW  SRAM address.
- sram_dq_o  out  16  SRAM data out.
- sram_dq_oe  out  1  data bus output enable, for the top-level tristate.
- sram_dq_i  in  16  SRAM data in.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low strobes.

## Operation
- Every output is registered.
- States: IDLE, RD, WSETUP, WPULSE, WHOLD, TURNAROUND. A 4-bit wait counter is used.
- IDLE: all strobes high; sram_dq_oe = 0.
- Acceptance (IDLE to RD or WSETUP):
  - When req = 1 at an edge in IDLE, latch addr[AW-1:0], d_in, be and we at that edge (the accept edge).
  - Go to RD or WSETUP. Strobes take their new values at the same edge.
- RD:
  - Lasts WAIT_RD+1 cycles.
  - Strobes: ce_n = 0, oe_n = 0, lb_n = ub_n = 0 (reads are always full-word); sram_dq_oe = 0.
  - At the edge ending the last RD cycle: d_out <= sram_dq_i, ack <= 1, all strobes go high.
- WSETUP:
  - Lasts 1 cycle.
  - Strobes: ce_n = 0, we_n = 1, lb_n = ~be[0], ub_n = ~be[1]; sram_dq_o = latched data; sram_dq_oe = 1.
- WPULSE: as WSETUP, but we_n = 0, for WAIT_WR+1 cycles.
- WHOLD:
  - Lasts 1 cycle; we_n = 1 with data and ce still driven.
  - At its ending edge: ack <= 1, sram_dq_oe <= 0, all strobes go high.
- Writes with be = 00 still run the full cycle and ack, but lb_n and ub_n stay high throughout.
- TURNAROUND:
  - Lasts TURN cycles; strobes high, dq_oe = 0.
  - Skipped entirely when TURN = 0.
- Request and ack rules:
  - req is ignored while busy = 1.
  - The requester must hold its request fields stable only up to the accept edge.
  - The requester must drop req in the ack cycle unless it is presenting the next request.
  - With TURN = 0 and req high during the ack cycle, the next access is accepted at the edge ending the ack cycle (back-to-back).
- sram_a holds its last value while idle.
- d_out holds its value until the next read completes.
- Reset values: state IDLE; ce_n, oe_n, we_n, lb_n, ub_n = 1; sram_dq_oe = 0; sram_a = 0; sram_dq_o = 0; d_out = 0; ack = 0; busy = 0.
- Reset mid-access: at the next edge all strobes go high and dq_oe goes to 0. The aborted access produces no ack and d_out is unchanged.
- rst has priority over req when both are high at the same edge.

## Timing
- Read latency: ack is registered high at accept edge + (WAIT_RD+1). Default: 3 clocks.
- Read strobe window: oe_n is low for exactly WAIT_RD+1 cycles.
- Write latency: ack is registered high at accept edge + (WAIT_WR+3). Default: 5 clocks.
- Write strobe window: we_n is low for exactly WAIT_WR+1 cycles. Address, data and ce are stable 1 cycle before we_n falls and 1 cycle after it rises.
- Throughput: next accept is no earlier than the ack-cycle edge + TURN.
- busy rises at the accept edge and falls at the edge entering IDLE.

## Test plan
- Reset: hold rst 2 cycles with req = 1 -> all strobes high, dq_oe = 0, ack = 0, busy = 0, d_out = 0000; no access starts.
- Read, defaults: SRAM model returns 0xA5C3 at 0x12345; req, we = 0, addr = 0x12345 -> sram_a = 0x12345; oe_n low for 3 cycles; ack high in the 4th cycle after accept; d_out = A5C3; lb_n = ub_n = 0.
- Write, defaults: addr = 0x00010, d_in = 0xBEEF, be = 10 -> ub_n = 0, lb_n = 1; we_n low exactly 3 cycles; dq_oe high for 5 cycles; ack at accept + 5; model high byte = BE, low byte unchanged.
- Back-to-back, TURN = 0: keep req high with new fields during ack -> second access accepted at the edge ending the ack cycle, no idle gap.
- Busy guard: pulse req during a read with a different addr -> ignored; exactly one ack; sram_a unchanged.
- Reset mid-write (during WPULSE): we_n and ce_n high and dq_oe low at the next edge; no ack; busy = 0.
